// File: rtl/reg_bus_pkg.sv
// Shared constants, command entry layout and FSM states for the register-bus master.
// Optional feature macro: REG_BUS_MASTER_WR_ACK_EN (write acknowledge responses).
package reg_bus_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CMD_W  = 1 + ADDR_W + DATA_W;
    // Wide enough for the largest supported read latency (7).
    localparam int unsigned CNT_W  = 3;

    localparam logic BUS_OP_WR = 1'b1;
    localparam logic BUS_OP_RD = 1'b0;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitRd,
        StResp
    } state_e;

    // One command FIFO entry, packed as {op, addr, wr_data}.
    typedef struct packed {
        logic              op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wr_data;
    } cmd_t;

    function automatic cmd_t pack_cmd(input logic op, input logic [ADDR_W-1:0] addr,
                                      input logic [DATA_W-1:0] wr_data);
        cmd_t c;
        c.op      = op;
        c.addr    = addr;
        c.wr_data = wr_data;
        return c;
    endfunction

endpackage

// File: rtl/reg_bus_cmd_fifo.sv
// Synchronous single-clock command FIFO holding 33-bit {op, addr, wr_data} entries.
// The not-full flag is registered so it can drive the upstream ready directly.
module reg_bus_cmd_fifo
    import reg_bus_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [CMD_W-1:0] push_data,
    input  logic             pop,
    output logic [CMD_W-1:0] pop_data,
    output logic             empty,
    output logic             not_full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [CMD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             not_full_q;
    logic             do_push;
    logic             do_pop;

    // Guard both ends so a full push or an empty pop is silently ignored.
    assign do_push  = push && not_full_q;
    assign do_pop   = pop && (count_q != '0);
    assign empty    = (count_q == '0);
    assign not_full = not_full_q;
    assign pop_data = mem[rd_ptr_q];

    // Next occupancy from this cycle's push/pop.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointers, occupancy and registered not-full flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            not_full_q <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q    <= count_d;
            not_full_q <= (count_d != FULL_CNT);
        end
    end

    // Entry storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/reg_bus_master.sv
// Register-bus master: queues commands, issues them one at a time on a simple
// chip-select bus, waits RD_LAT cycles for read data and returns a response.
// Optional feature macro: REG_BUS_MASTER_WR_ACK_EN -- when defined, writes also
// produce a response (rd_data 0); otherwise writes complete silently.
module reg_bus_master
    import reg_bus_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wr_data,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic              rsp_op,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_rd_data,
    output logic              bus_cs,
    output logic              bus_op,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data
);

    state_e            state_q;
    state_e            state_d;
    cmd_t              cur_q;
    cmd_t              cur_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_not_full;
    logic [CMD_W-1:0]  fifo_head;

    reg_bus_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_vld),
        .push_data (pack_cmd(cmd_op, cmd_addr, cmd_wr_data)),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .not_full  (fifo_not_full)
    );

    assign cmd_rdy = fifo_not_full;

    // Transaction sequencing: pop in idle, one issue cycle, read wait, response hold.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        cnt_d     = cnt_q;
        rd_data_d = rd_data_q;
        fifo_pop  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cur_d    = cmd_t'(fifo_head);
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                if (cur_q.op == BUS_OP_WR) begin
`ifdef REG_BUS_MASTER_WR_ACK_EN
                    rd_data_d = '0;
                    state_d   = StResp;
`else
                    state_d   = StIdle;
`endif
                end else begin
                    // Counts down to zero; the cycle with zero is the last wait cycle.
                    cnt_d   = CNT_W'(RD_LAT - 1);
                    state_d = StWaitRd;
                end
            end
            StWaitRd: begin
                if (cnt_q == '0) begin
                    rd_data_d = bus_rd_data;
                    state_d   = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                if (rsp_rdy) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state, current command, wait counter and captured read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cur_q     <= '0;
            cnt_q     <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Bus and response outputs are zero outside their owning state.
    always_comb begin
        bus_cs      = (state_q == StIssue);
        bus_op      = 1'b0;
        bus_addr    = '0;
        bus_wr_data = '0;
        rsp_vld     = (state_q == StResp);
        rsp_op      = 1'b0;
        rsp_addr    = '0;
        rsp_rd_data = '0;
        if (bus_cs) begin
            bus_op      = cur_q.op;
            bus_addr    = cur_q.addr;
            bus_wr_data = cur_q.wr_data;
        end
        if (rsp_vld) begin
            rsp_op      = cur_q.op;
            rsp_addr    = cur_q.addr;
            rsp_rd_data = rd_data_q;
        end
    end

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench for reg_bus_master with a small register-bus responder and a
// response scoreboard. Honours REG_BUS_MASTER_WR_ACK_EN when defined.
module tb_reg_bus_master;
    import reg_bus_pkg::*;

    localparam logic [2:0] STAT = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_vld = 1'b0;
    logic        cmd_rdy;
    logic        cmd_op = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [15:0] cmd_wr_data = '0;
    logic        rsp_vld;
    logic        rsp_rdy = 1'b0;
    logic        rsp_op;
    logic [15:0] rsp_addr;
    logic [15:0] rsp_rd_data;
    logic        bus_cs;
    logic        bus_op;
    logic [15:0] bus_addr;
    logic [15:0] bus_wr_data;
    logic [15:0] bus_rd_data = '0;

    reg_bus_master #(
        .FIFO_DEPTH (4),
        .RD_LAT     (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_vld     (cmd_vld),
        .cmd_rdy     (cmd_rdy),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_wr_data (cmd_wr_data),
        .rsp_vld     (rsp_vld),
        .rsp_rdy     (rsp_rdy),
        .rsp_op      (rsp_op),
        .rsp_addr    (rsp_addr),
        .rsp_rd_data (rsp_rd_data),
        .bus_cs      (bus_cs),
        .bus_op      (bus_op),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .bus_rd_data (bus_rd_data)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder: scratch register at 0x0009, status at 0x0008, rest reads 0.
    logic [15:0] resp_scratch = '0;
    always @(posedge clk) begin
        if (bus_cs) begin
            if (bus_op) begin
                if (bus_addr == 16'h0009) resp_scratch <= bus_wr_data;
            end else begin
                case (bus_addr)
                    16'h0008: bus_rd_data <= {13'd0, STAT};
                    16'h0009: bus_rd_data <= resp_scratch;
                    default:  bus_rd_data <= 16'h0000;
                endcase
            end
        end
    end

    // Longest run of consecutive bus_cs cycles.
    int cs_run = 0;
    int cs_max = 0;
    always @(negedge clk) begin
        if (bus_cs) begin
            cs_run <= cs_run + 1;
            if (cs_run + 1 > cs_max) cs_max <= cs_run + 1;
        end else begin
            cs_run <= 0;
        end
    end

    typedef struct {
        logic        op;
        logic [15:0] addr;
        logic [15:0] data;
    } rsp_t;

    rsp_t        sb[$];
    logic [15:0] shadow_scratch = '0;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [15:0] exp_rd(input logic [15:0] addr);
        case (addr)
            16'h0008: return {13'd0, STAT};
            16'h0009: return shadow_scratch;
            default:  return 16'h0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one command; returns at accept edge + 1, or after budget cycles.
    task automatic send(input logic op, input logic [15:0] addr, input logic [15:0] data,
                        input int budget, output bit ok);
        rsp_t e;
        ok          = 1'b0;
        cmd_vld     = 1'b1;
        cmd_op      = op;
        cmd_addr    = addr;
        cmd_wr_data = data;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cmd_rdy) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        cmd_vld = 1'b0;
        if (ok) begin
            e.op   = op;
            e.addr = addr;
            if (op == BUS_OP_RD) begin
                e.data = exp_rd(addr);
                sb.push_back(e);
            end else begin
                if (addr == 16'h0009) shadow_scratch = data;
`ifdef REG_BUS_MASTER_WR_ACK_EN
                e.data = 16'h0000;
                sb.push_back(e);
`endif
            end
        end
    endtask

    // Wait for a response, compare with the scoreboard head, consume it.
    task automatic take_rsp(input string tag, input int budget);
        bit   seen = 1'b0;
        rsp_t e;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rsp_vld) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, " rsp_vld"}, seen, 1);
        if (seen) begin
            chk({tag, " sb has entry"}, sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({tag, " rsp_op"}, rsp_op, e.op);
                chk({tag, " rsp_addr"}, rsp_addr, e.addr);
                chk({tag, " rsp_rd_data"}, rsp_rd_data, e.data);
            end
            rsp_rdy = 1'b1;
        end
        @(posedge clk);
        #1;
        rsp_rdy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic [15:0] stall_addr [6];
    bit          ok;

    initial begin
        stall_addr[0] = 16'h0008;
        stall_addr[1] = 16'h0009;
        stall_addr[2] = 16'h1234;
        stall_addr[3] = 16'h0008;
        stall_addr[4] = 16'h0009;
        stall_addr[5] = 16'h0002;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset cmd_rdy", cmd_rdy, 1);
        chk("reset bus", {bus_cs, bus_op, bus_addr, bus_wr_data}, 0);
        chk("reset rsp", {rsp_vld, rsp_op, rsp_addr, rsp_rd_data}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write 0x0001 to 0x0009: single bus_cs cycle at k+1..k+2.
        send(BUS_OP_WR, 16'h0009, 16'h0001, 5, ok);
        chk("wr accepted", ok, 1);
        @(negedge clk);
        chk("wr cs before issue", bus_cs, 0);
        @(negedge clk);
        chk("wr bus_cs", bus_cs, 1);
        chk("wr bus_op", bus_op, 1);
        chk("wr bus_addr", bus_addr, 16'h0009);
        chk("wr bus_wr_data", bus_wr_data, 16'h0001);
        @(negedge clk);
        chk("wr cs one cycle", bus_cs, 0);
`ifdef REG_BUS_MASTER_WR_ACK_EN
        chk("wr ack at k+2", rsp_vld, 1);
        @(posedge clk);
        #1;
        take_rsp("wr ack", 4);
`else
        chk("wr no response", rsp_vld, 0);
        @(posedge clk);
        #1;
`endif

        // Read 0x0009 back: bus at k+1, response from k+3.
        send(BUS_OP_RD, 16'h0009, 16'h0000, 5, ok);
        chk("rd accepted", ok, 1);
        @(negedge clk);
        chk("rd cs before issue", bus_cs, 0);
        @(negedge clk);
        chk("rd bus", {bus_cs, bus_op, bus_addr}, {1'b1, 1'b0, 16'h0009});
        @(negedge clk);
        chk("rd wait no rsp", {bus_cs, rsp_vld}, 0);
        @(negedge clk);
        chk("rd rsp at k+3", rsp_vld, 1);
        @(posedge clk);
        #1;
        take_rsp("rd 0x0009", 4);

        // Status register and unmapped address.
        send(BUS_OP_RD, 16'h0008, 16'h0000, 5, ok);
        take_rsp("rd stat", 8);
        send(BUS_OP_RD, 16'h1234, 16'h0000, 5, ok);
        take_rsp("rd unmapped", 8);

        // Stalled response with a filling FIFO.
        rsp_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(BUS_OP_RD, stall_addr[i], 16'h0000, 6, ok);
            chk("stall push", ok, 1);
        end
        @(negedge clk);
        chk("cmd_rdy low when full", cmd_rdy, 0);
        @(posedge clk);
        #1;
        send(BUS_OP_RD, stall_addr[5], 16'h0000, 3, ok);
        chk("6th held off", ok, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall no bus_cs", bus_cs, 0);
            if (sb.size() != 0)
                chk("stall rsp stable", {rsp_vld, rsp_op, rsp_addr, rsp_rd_data},
                    {1'b1, 1'b0, sb[0].addr, sb[0].data});
        end
        @(posedge clk);
        #1;
        take_rsp("stall rsp 0", 4);
        send(BUS_OP_RD, stall_addr[5], 16'h0000, 10, ok);
        chk("6th accepted", ok, 1);
        for (int i = 1; i < 6; i++) take_rsp("stall drain", 10);

        // Reset while waiting for read data.
        send(BUS_OP_RD, 16'h0009, 16'h0000, 5, ok);
        send(BUS_OP_RD, 16'h0008, 16'h0000, 5, ok);
        @(negedge clk);
        chk("pre-reset issue", bus_cs, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst bus zero", {bus_cs, bus_op, bus_addr, bus_wr_data}, 0);
        chk("rst rsp zero", {rsp_vld, rsp_op, rsp_addr, rsp_rd_data}, 0);
        chk("rst cmd_rdy", cmd_rdy, 1);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post-reset quiet", {bus_cs, rsp_vld}, 0);
        end
        @(posedge clk);
        #1;
        send(BUS_OP_RD, 16'h0009, 16'h0000, 5, ok);
        take_rsp("post-reset rd", 8);

        chk("bus_cs max run", cs_max, 1);
        chk("scoreboard drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
